// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer_if
// Description : Instruction-fetch request/ready bus between sequencer and imem.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the
//               RV32 subset core. Optional retired-instruction counter is
//               built only when SEQ_INSTRET_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    core_sequencer_if.master    imem,
    output logic [31:0]         ir,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    input  logic                regwrite,
    input  logic                branch,
    input  logic [XLEN-1:0]     imm,
    input  logic                alu_zero,
    output logic                rf_we,
    output logic [2:0]          state,
    output logic                halted,
    output logic                fault,
    output logic [31:0]         instret
);

    localparam logic [31:0] c_nop       = 32'h0000_0013;
    localparam logic [6:0]  c_op_rtype  = 7'b0110011;
    localparam logic [6:0]  c_op_itype  = 7'b0010011;
    localparam logic [6:0]  c_op_branch = 7'b1100011;
    localparam logic [6:0]  c_op_jal    = 7'b1101111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_next_pc;
    logic            r_self_jump;
    logic            w_restart;
    logic            w_fault_set;
    logic            w_halt_set;
    logic            w_req;
    logic            w_rf_we;
    logic [6:0]      w_opcode;
    logic            w_legal;
    logic            w_is_jal;
    logic            w_take;
    logic [XLEN-1:0] w_target;

    assign w_opcode = ir[6:0];
    assign w_legal  = (w_opcode == c_op_rtype) || (w_opcode == c_op_itype) ||
                      (w_opcode == c_op_branch) || (w_opcode == c_op_jal);
    assign w_is_jal = (w_opcode == c_op_jal);
    // bne is the only conditional branch; other branch funct3 values fall through
    assign w_take   = w_is_jal ||
                      (branch && (w_opcode == c_op_branch) && (ir[14:12] == 3'b001) && !alu_zero);
    assign pc_plus4 = pc + XLEN'(4);
    assign w_target = w_take ? (pc + imm) : pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_rf_we      = 1'b0;
        w_restart    = 1'b0;
        w_fault_set  = 1'b0;
        w_halt_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (imem.ready) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_next = S_EXECUTE;
                end else begin
                    w_fault_set  = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_EXECUTE: begin
                if (w_target[1:0] != 2'b00) begin
                    w_fault_set  = 1'b1;
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                w_rf_we = regwrite;
                if (r_self_jump) begin
                    w_halt_set   = 1'b1;
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            ir          <= c_nop;
            r_next_pc   <= RESET_PC;
            r_self_jump <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            if (w_restart) begin
                pc     <= RESET_PC;
                halted <= 1'b0;
                fault  <= 1'b0;
            end
            if ((r_state == S_FETCH) && imem.ready) begin
                ir <= imem.rdata;
            end
            // Halt-on-self-jump is decided here so WRITEBACK needs no live imm
            if (r_state == S_EXECUTE) begin
                r_next_pc   <= w_target;
                r_self_jump <= w_is_jal && (imm == '0);
            end
            if (r_state == S_WRITEBACK) begin
                pc <= r_next_pc;
            end
            if (w_halt_set) begin
                halted <= 1'b1;
            end
            if (w_fault_set) begin
                fault  <= 1'b1;
                halted <= 1'b1;
            end
        end
    end

`ifdef SEQ_INSTRET_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_restart) begin
            r_instret <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

    assign imem.req  = w_req;
    assign imem.addr = pc;
    assign rf_we     = w_rf_we;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench for core_sequencer against an
//               instruction-level reference model with random programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            regwrite;
    logic            branch;
    logic [XLEN-1:0] imm;
    logic            alu_zero;
    logic            rf_we;
    logic [2:0]      state;
    logic            halted;
    logic            fault;
    logic [31:0]     instret;

    core_sequencer_if #(.XLEN(XLEN)) imem_bus ();

    core_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .imem     (imem_bus.master),
        .ir       (ir),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .regwrite (regwrite),
        .branch   (branch),
        .imm      (imm),
        .alu_zero (alu_zero),
        .rf_we    (rf_we),
        .state    (state),
        .halted   (halted),
        .fault    (fault),
        .instret  (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program image: word, immediate and ALU zero flag per word slot
    logic [31:0] mem_w   [64];
    logic [31:0] mem_imm [64];
    logic        mem_z   [64];

    // Control unit / immediate generator / ALU stand-ins
    assign regwrite = (ir[6:0] == 7'h33) || (ir[6:0] == 7'h13) || (ir[6:0] == 7'h6f);
    assign branch   = (ir[6:0] == 7'h63) || (ir[6:0] == 7'h6f);
    assign imm      = mem_imm[pc[7:2]];
    assign alu_zero = mem_z[pc[7:2]];

    int          total;
    int          bad;
    int          fixed_wait;
    bit          force_ready;
    logic [31:0] m_pc;
    logic [31:0] last_ir;
    int          m_ret;
    bit          m_halted;
    int          cyc;
    int          first_req;
    int          first_wb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_instret();
`ifdef SEQ_INSTRET_EN
        return 32'(m_ret);
`else
        return 32'h0;
`endif
    endfunction

    // One instruction at architectural level
    function automatic void exec(input logic [31:0] a, output bit flt, output logic [31:0] npc,
                                 output bit we, output bit selfh);
        logic [31:0] w;
        logic [31:0] im;
        logic [6:0]  op;
        w   = mem_w[a[7:2]];
        im  = mem_imm[a[7:2]];
        op  = w[6:0];
        npc = a + 32'd4;
        if (op == 7'h6f)
            npc = a + im;
        else if (op == 7'h63 && w[14:12] == 3'b001 && !mem_z[a[7:2]])
            npc = a + im;
        flt   = !(op inside {7'h33, 7'h13, 7'h63, 7'h6f}) || (npc[1:0] != 2'b00);
        we    = op inside {7'h33, 7'h13, 7'h6f};
        selfh = (op == 7'h6f) && (im == 32'h0);
    endfunction

    initial begin : responder
        int cnt;
        int cur;
        cnt = 0;
        cur = 0;
        imem_bus.ready = 1'b0;
        imem_bus.rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (force_ready) begin
                imem_bus.ready = 1'b1;
                imem_bus.rdata = mem_w[0];
            end else if (!imem_bus.req) begin
                imem_bus.ready = 1'b0;
                imem_bus.rdata = $urandom;
                cnt = 0;
                cur = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end else if (cnt >= cur) begin
                imem_bus.ready = 1'b1;
                imem_bus.rdata = mem_w[imem_bus.addr[7:2]];
            end else begin
                imem_bus.ready = 1'b0;
                imem_bus.rdata = $urandom;
                cnt++;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},   {29'b0, state},        32'd0);
        check({tag, "_pc"},      pc,                    32'h0);
        check({tag, "_ir"},      ir,                    32'h13);
        check({tag, "_req"},     {31'b0, imem_bus.req}, 32'd0);
        check({tag, "_rf_we"},   {31'b0, rf_we},        32'd0);
        check({tag, "_halted"},  {31'b0, halted},       32'd0);
        check({tag, "_fault"},   {31'b0, fault},        32'd0);
        check({tag, "_instret"}, instret,               32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n    = 1'b1;
        last_ir  = 32'h13;
        m_pc     = 32'h0;
        m_ret    = 0;
        m_halted = 1'b0;
    endtask

    task automatic fill_nops();
        for (int i = 0; i < 64; i++) begin
            mem_w[i]   = 32'h0000_0013;
            mem_imm[i] = $urandom;
            mem_z[i]   = 1'b0;
        end
    endtask

    // Start the core and track it instruction by instruction until halt or max_ret retirements
    task automatic run(input int max_ret);
        bit          flt;
        bit          we;
        bit          sh;
        logic [31:0] npc;
        bit          done;
        @(negedge clk);
        start     = 1'b1;
        m_pc      = 32'h0;
        m_ret     = 0;
        m_halted  = 1'b0;
        cyc       = 0;
        first_req = -1;
        first_wb  = -1;
        done      = 1'b0;
        while (!done) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) begin
                check("start_fetch",   {29'b0, state},  32'd1);
                check("start_halted",  {31'b0, halted}, 32'd0);
                check("start_fault",   {31'b0, fault},  32'd0);
                check("start_instret", instret,         32'd0);
            end
            case (state)
                3'd1: begin
                    if (first_req < 0) first_req = cyc;
                    check("fetch_after_halt", {31'b0, m_halted}, 32'd0);
                    check("fetch_addr", imem_bus.addr, m_pc);
                    check("ir_hold", ir, last_ir);
                end
                3'd2: begin
                    check("ir_load", ir, mem_w[m_pc[7:2]]);
                    last_ir = mem_w[m_pc[7:2]];
                end
                3'd4: begin
                    exec(m_pc, flt, npc, we, sh);
                    if (first_wb < 0) first_wb = cyc;
                    check("wb_state", {29'b0, state}, flt ? 32'd5 : 32'd4);
                    check("wb_rf_we", {31'b0, rf_we}, {31'b0, we});
                    check("wb_pc", pc, m_pc);
                    check("wb_instret", instret, exp_instret());
                    m_pc = npc;
                    m_ret++;
                    if (sh) m_halted = 1'b1;
                    else if (m_ret >= max_ret) done = 1'b1;
                end
                3'd5: begin
                    if (m_halted) begin
                        check("halt_fault", {31'b0, fault}, 32'd0);
                    end else begin
                        exec(m_pc, flt, npc, we, sh);
                        check("halt_cause", {31'b0, flt}, 32'd1);
                        check("halt_fault", {31'b0, fault}, 32'd1);
                    end
                    check("halt_halted", {31'b0, halted}, 32'd1);
                    check("halt_pc", pc, m_pc);
                    check("halt_instret", instret, exp_instret());
                    check("halt_req", {31'b0, imem_bus.req}, 32'd0);
                    m_halted = 1'b1;
                    done     = 1'b1;
                end
                default: ;
            endcase
            if (state != 3'd4) check("rf_we_quiet", {31'b0, rf_we}, 32'd0);
            if (cyc > 3000) begin
                check("timeout", 32'(cyc), 32'd0);
                done = 1'b1;
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        start       = 1'b0;
        rst_n       = 1'b0;
        fixed_wait  = 0;
        force_ready = 1'b0;
        last_ir     = 32'h13;
        m_pc        = 32'h0;
        m_ret       = 0;
        m_halted    = 1'b0;
        fill_nops();
        repeat (2) @(negedge clk);
        check_reset_vals("init");
        rst_n = 1'b1;

        // addi x1,x0,5 then jal x0,0 with zero-wait memory
        fill_nops();
        mem_w[0] = 32'h0050_0093;
        mem_w[1] = 32'h0000_006f;
        mem_imm[1] = 32'h0;
        fixed_wait = 0;
        run(100);
        check("t1_first_req", 32'(first_req), 32'd1);
        check("t1_first_wb", 32'(first_wb), 32'd4);

        // three-cycle fetch wait
        fixed_wait = 3;
        run(100);
        check("t2_first_req", 32'(first_req), 32'd1);
        check("t2_first_wb", 32'(first_wb), 32'd7);

        // bne at 0x10, imm -8, taken
        fill_nops();
        mem_w[4]   = 32'h0010_1463;
        mem_imm[4] = 32'hFFFF_FFF8;
        mem_z[4]   = 1'b0;
        fixed_wait = -1;
        run(5);
        @(negedge clk);
        check("bne_taken_pc", pc, 32'h8);
        do_reset();

        // bne not taken, then end of program
        mem_z[4]   = 1'b1;
        mem_w[5]   = 32'h0000_006f;
        mem_imm[5] = 32'h0;
        run(5);
        @(negedge clk);
        check("bne_fall_pc", pc, 32'h14);
        do_reset();

        // jal x0,0 at 0x20
        fill_nops();
        mem_w[8]   = 32'h0000_006f;
        mem_imm[8] = 32'h0;
        run(100);
        check("jal_halt_pc", pc, 32'h20);
        repeat (4) begin
            @(negedge clk);
            check("halt_no_req", {31'b0, imem_bus.req}, 32'd0);
            check("halt_stay", {29'b0, state}, 32'd5);
        end

        // illegal opcode
        fill_nops();
        mem_w[2] = 32'h0000_0003;
        run(100);
        check("illegal_fault", {31'b0, fault}, 32'd1);
        check("illegal_pc", pc, 32'h8);

        // misaligned branch target
        fill_nops();
        mem_w[1]   = 32'h0010_1463;
        mem_imm[1] = 32'h2;
        mem_z[1]   = 1'b0;
        run(100);
        check("misalign_fault", {31'b0, fault}, 32'd1);
        check("misalign_pc", pc, 32'h4);

        // async reset during a long fetch wait, then a stray ready
        fill_nops();
        fixed_wait = 10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_req_before", {31'b0, imem_bus.req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6");
        force_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_idle", {29'b0, state}, 32'd0);
            check("t6_ir", ir, 32'h13);
        end
        force_ready = 1'b0;
        last_ir     = 32'h13;

        // random programs
        fixed_wait = -1;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 64; i++) begin
                int          r;
                int          tgt;
                logic [31:0] rw;
                r          = int'($urandom_range(0, 99));
                tgt        = int'($urandom_range(0, 63));
                rw         = $urandom;
                mem_imm[i] = $urandom;
                mem_z[i]   = rw[0];
                if (r < 35) begin
                    mem_w[i] = {rw[31:7], 7'h13};
                end else if (r < 55) begin
                    mem_w[i] = {rw[31:7], 7'h33};
                end else if (r < 78) begin
                    mem_w[i]   = {rw[31:15], (r < 72) ? 3'b001 : rw[14:12], rw[11:7], 7'h63};
                    mem_imm[i] = 32'((tgt - i) * 4);
                end else if (r < 90) begin
                    mem_w[i]   = {rw[31:7], 7'h6f};
                    mem_imm[i] = 32'((tgt - i) * 4);
                end else if (r < 95) begin
                    mem_w[i]   = r[0] ? {rw[31:7], 7'h6f} : {rw[31:15], 3'b001, rw[11:7], 7'h63};
                    mem_imm[i] = 32'((tgt - i) * 4 + 2);
                    mem_z[i]   = 1'b0;
                end else begin
                    mem_w[i] = {rw[31:7], 7'h03};
                end
            end
            run(30);
            if (!m_halted) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
